// File: rtl/meas_seq.sv
// Measurement sequencer for the PUF oscillator array: clear, count window, challenge walk, ID handshake.
// Optional select-pair range/duplicate check is built when MEAS_SEQ_SELCHK_EN is defined.
module meas_seq #(
   parameter int C_IOSCNUM      = 48,
   parameter int C_OIDWIDTH     = 24,
   parameter int C_SELWIDTH     = 8,
   parameter int C_MEMADDRWIDTH = 24,
   parameter int C_MEMSTADDR    = 0,
   parameter int C_CLRCYC       = 4,
   parameter int C_WINCYC       = 1024,
   parameter int C_CNTWIDTH     = 16,
   parameter int C_SETTLE       = 2
) (
   input  logic                      I_sclk,
   input  logic                      I_rst,
   input  logic                      I_start,
   input  logic [C_SELWIDTH-1:0]     I_mem_data,
   input  logic                      I_comp,
   input  logic                      I_id_ack,
   output logic                      O_osc_rst_n,
   output logic                      O_osc_en,
   output logic [C_SELWIDTH-1:0]     O_sel_1,
   output logic [C_SELWIDTH-1:0]     O_sel_2,
   output logic [C_MEMADDRWIDTH-1:0] O_mem_addr,
   output logic [C_OIDWIDTH-1:0]     O_id,
   output logic                      O_id_v,
   output logic                      O_busy,
   output logic                      O_sel_err
);

   // state | meaning
   // IDLE  | waiting for I_start, oscillator counters held cleared
   // CLR   | counters cleared for C_CLRCYC cycles
   // WIN   | oscillators counting for C_WINCYC cycles
   // FA    | fetch mux 1 select from challenge memory
   // FB    | fetch mux 2 select from challenge memory
   // SET   | mux/comparator settle for C_SETTLE cycles
   // CMP   | shift comparator result into the ID
   // DONE  | ID valid, waiting for I_id_ack
   typedef enum logic [2:0] {
      S_IDLE, S_CLR, S_WIN, S_FA, S_FB, S_SET, S_CMP, S_DONE
   } state_t;

   localparam int BITW = $clog2(C_OIDWIDTH + 1);
   localparam logic [C_CNTWIDTH-1:0]     CNT_ONE  = C_CNTWIDTH'(1);
   localparam logic [C_CNTWIDTH-1:0]     CLR_LD   = C_CNTWIDTH'(C_CLRCYC - 1);
   localparam logic [C_CNTWIDTH-1:0]     WIN_LD   = C_CNTWIDTH'(C_WINCYC - 1);
   localparam logic [C_CNTWIDTH-1:0]     SET_LD   = C_CNTWIDTH'(C_SETTLE - 1);
   localparam logic [BITW-1:0]           BIT_ONE  = BITW'(1);
   localparam logic [BITW-1:0]           BIT_LAST = BITW'(C_OIDWIDTH - 1);
   localparam logic [C_MEMADDRWIDTH-1:0] ADDR_ST  = C_MEMADDRWIDTH'(C_MEMSTADDR);
   localparam logic [C_MEMADDRWIDTH-1:0] ADDR_ONE = C_MEMADDRWIDTH'(1);

   if (C_CLRCYC < 1 || C_WINCYC < 1 || C_SETTLE < 1 || C_OIDWIDTH < 2) begin : g_bad_len
      $error("meas_seq: C_CLRCYC, C_WINCYC, C_SETTLE must be >= 1 and C_OIDWIDTH >= 2");
   end
   if (C_WINCYC >= (1 << C_CNTWIDTH) || C_CLRCYC >= (1 << C_CNTWIDTH)) begin : g_bad_cnt
      $error("meas_seq: C_CNTWIDTH too narrow for the cycle counts");
   end

   state_t              state, state_nx;
   logic [C_CNTWIDTH-1:0] cnt, cnt_nx;
   logic [BITW-1:0]     bit_cnt, bit_cnt_nx;
   logic                pair_bad;

   always_ff @(posedge I_sclk) begin
      if (!I_rst) begin
         state   <= S_IDLE;
         cnt     <= '0;
         bit_cnt <= '0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         bit_cnt <= bit_cnt_nx;
      end
   end

   // Single down-counter shared by CLR, WIN and SET; each phase ends at terminal count zero.
   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      bit_cnt_nx = bit_cnt;
      case (state)
         S_IDLE: begin
            if (I_start) begin
               state_nx   = S_CLR;
               cnt_nx     = CLR_LD;
               bit_cnt_nx = '0;
            end
         end
         S_CLR: begin
            if (cnt == '0) begin
               state_nx = S_WIN;
               cnt_nx   = WIN_LD;
            end else begin
               cnt_nx = cnt - CNT_ONE;
            end
         end
         S_WIN: begin
            if (cnt == '0) state_nx = S_FA;
            else           cnt_nx   = cnt - CNT_ONE;
         end
         S_FA: state_nx = S_FB;
         S_FB: begin
            state_nx = S_SET;
            cnt_nx   = SET_LD;
         end
         S_SET: begin
            if (cnt == '0) state_nx = S_CMP;
            else           cnt_nx   = cnt - CNT_ONE;
         end
         S_CMP: begin
            bit_cnt_nx = bit_cnt + BIT_ONE;
            state_nx   = (bit_cnt == BIT_LAST) ? S_DONE : S_FA;
         end
         S_DONE: begin
            if (I_id_ack) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge I_sclk) begin
      if (!I_rst) begin
         O_osc_rst_n <= 1'b0;
         O_osc_en    <= 1'b0;
         O_busy      <= 1'b0;
         O_id_v      <= 1'b0;
         O_sel_1     <= '0;
         O_sel_2     <= '0;
         O_id        <= '0;
         O_mem_addr  <= ADDR_ST;
      end else begin
         O_osc_rst_n <= (state_nx != S_IDLE) && (state_nx != S_CLR);
         O_osc_en    <= (state_nx == S_WIN);
         O_busy      <= (state_nx != S_IDLE);
         O_id_v      <= (state_nx == S_DONE);
         case (state)
            S_IDLE: begin
               if (I_start) begin
                  O_id       <= '0;
                  O_mem_addr <= ADDR_ST;
               end
            end
            S_FA: begin
               O_sel_1    <= I_mem_data;
               O_mem_addr <= O_mem_addr + ADDR_ONE;
            end
            S_FB: begin
               O_sel_2    <= I_mem_data;
               O_mem_addr <= O_mem_addr + ADDR_ONE;
            end
            S_CMP: O_id <= {O_id[C_OIDWIDTH-2:0], I_comp & ~pair_bad};
            default: ;
         endcase
      end
   end

`ifdef MEAS_SEQ_SELCHK_EN
   localparam logic [C_SELWIDTH:0] SEL_LIM = (C_SELWIDTH + 1)'(C_IOSCNUM);

   logic sel_chk_bad;
   assign sel_chk_bad = ({1'b0, O_sel_1} >= SEL_LIM) || ({1'b0, I_mem_data} >= SEL_LIM)
                        || (O_sel_1 == I_mem_data);

   // pair_bad lives for one pair only; O_sel_err is sticky until the next start.
   always_ff @(posedge I_sclk) begin
      if (!I_rst) begin
         pair_bad  <= 1'b0;
         O_sel_err <= 1'b0;
      end else if (state == S_IDLE && I_start) begin
         pair_bad  <= 1'b0;
         O_sel_err <= 1'b0;
      end else if (state == S_FB) begin
         pair_bad <= sel_chk_bad;
         if (sel_chk_bad) O_sel_err <= 1'b1;
      end
   end
`else
   assign pair_bad  = 1'b0;
   assign O_sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_meas_seq.sv
// Directed bench for meas_seq: default instance plus a second instance whose start address wraps.
// Expectations for the select-check run follow MEAS_SEQ_SELCHK_EN.
module tb_meas_seq;

   localparam int WRAP_BASE = (1 << 24) - 4;

   logic       clk = 1'b0;
   logic       rst, start, ack, comp, comp_alt;
   logic [7:0] mem [0:63];

   logic        osc_rst_n, osc_en, id_v, busy, sel_err;
   logic [7:0]  sel_1, sel_2, mem_data;
   logic [23:0] mem_addr, id;

   logic        w_osc_rst_n, w_osc_en, w_id_v, w_busy, w_sel_err;
   logic [7:0]  w_sel_1, w_sel_2, w_mem_data;
   logic [23:0] w_mem_addr, w_id, w_off;

   int checks = 0;
   int errors = 0;
   int n, en_cnt, bad_cnt;

   always #5 clk = ~clk;

   assign mem_data   = mem[mem_addr[5:0]];
   assign w_off      = w_mem_addr - 24'(WRAP_BASE);
   assign w_mem_data = w_off[7:0];
   // Alternate mode: pair k has sel_1 = 2k, so ~sel_1[1] gives 1 for pair 0, 0 for pair 1, ...
   assign comp = comp_alt ? ~sel_1[1] : 1'b1;

   meas_seq dut (
      .I_sclk(clk), .I_rst(rst), .I_start(start), .I_mem_data(mem_data),
      .I_comp(comp), .I_id_ack(ack),
      .O_osc_rst_n(osc_rst_n), .O_osc_en(osc_en), .O_sel_1(sel_1), .O_sel_2(sel_2),
      .O_mem_addr(mem_addr), .O_id(id), .O_id_v(id_v), .O_busy(busy), .O_sel_err(sel_err)
   );

   meas_seq #(.C_MEMSTADDR(WRAP_BASE)) dut_wrap (
      .I_sclk(clk), .I_rst(rst), .I_start(start), .I_mem_data(w_mem_data),
      .I_comp(comp), .I_id_ack(ack),
      .O_osc_rst_n(w_osc_rst_n), .O_osc_en(w_osc_en), .O_sel_1(w_sel_1), .O_sel_2(w_sel_2),
      .O_mem_addr(w_mem_addr), .O_id(w_id), .O_id_v(w_id_v), .O_busy(w_busy),
      .O_sel_err(w_sel_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Start on edge 0 and count edges until O_id_v is seen (bounded).
   task automatic run(output int edges, output int en_c, output int bad_c);
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      edges = 0; en_c = 0; bad_c = 0;
      while (id_v !== 1'b1 && edges < 3000) begin
         @(posedge clk);
         #1;
         edges++;
         if (osc_en === 1'b1) en_c++;
         if (osc_en === 1'b1 && osc_rst_n !== 1'b1) bad_c++;
      end
   endtask

   task automatic do_ack();
      @(negedge clk) ack = 1'b1;
      @(posedge clk);
      #1;
      chk("ack_id_v", id_v, 1'b0);
      chk("ack_busy", busy, 1'b0);
      chk("ack_osc_rst_n", osc_rst_n, 1'b0);
      ack = 1'b0;
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; ack = 1'b0; comp_alt = 1'b0;
      for (int i = 0; i < 64; i++) mem[i] = 8'(i);

      repeat (3) @(posedge clk);
      #1;
      chk("rst_osc_rst_n", osc_rst_n, 1'b0);
      chk("rst_osc_en", osc_en, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_id_v", id_v, 1'b0);
      chk("rst_id", id, 24'h0);
      chk("rst_sel_1", sel_1, 8'h0);
      chk("rst_sel_2", sel_2, 8'h0);
      chk("rst_sel_err", sel_err, 1'b0);
      chk("rst_mem_addr", mem_addr, 24'h0);
      chk("rst_wrap_addr", w_mem_addr, 24'hFFFFFC);
      @(negedge clk) rst = 1'b1;

      // Run 1: constant comparator
      run(n, en_cnt, bad_cnt);
      chk("r1_done_edge", n, 1148);
      chk("r1_en_cycles", en_cnt, 1024);
      chk("r1_en_while_clr", bad_cnt, 0);
      chk("r1_id", id, 24'hFFFFFF);
      chk("r1_mem_addr", mem_addr, 24'd48);
      chk("r1_sel_1", sel_1, 8'd46);
      chk("r1_sel_2", sel_2, 8'd47);
      chk("r1_osc_rst_n", osc_rst_n, 1'b1);
      chk("r1_osc_en", osc_en, 1'b0);
      chk("r1_busy", busy, 1'b1);
      chk("r1_sel_err", sel_err, 1'b0);
      chk("wrap_id_v", w_id_v, 1'b1);
      chk("wrap_id", w_id, 24'hFFFFFF);
      chk("wrap_mem_addr", w_mem_addr, 24'd44);

      // DONE hold with start pulses and no ack
      for (int i = 0; i < 100; i++) begin
         @(negedge clk) start = (i % 2 == 0);
         @(posedge clk);
         #1;
         chk("hold_id_v", id_v, 1'b1);
         chk("hold_id", id, 24'hFFFFFF);
      end
      @(negedge clk) start = 1'b0;
      do_ack();

      // Run 2: alternating comparator, first pair returns 1
      comp_alt = 1'b1;
      run(n, en_cnt, bad_cnt);
      chk("r2_done_edge", n, 1148);
      chk("r2_id", id, 24'hAAAAAA);
      do_ack();
      comp_alt = 1'b0;

      // Reset in WIN cycle 500, asserted together with start
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (504) @(posedge clk);
      #1;
      chk("win_osc_en", osc_en, 1'b1);
      chk("win_osc_rst_n", osc_rst_n, 1'b1);
      @(negedge clk) begin rst = 1'b0; start = 1'b1; end
      @(posedge clk);
      #1;
      chk("mrst_osc_en", osc_en, 1'b0);
      chk("mrst_busy", busy, 1'b0);
      chk("mrst_mem_addr", mem_addr, 24'h0);
      chk("mrst_osc_rst_n", osc_rst_n, 1'b0);
      chk("mrst_id", id, 24'h0);
      chk("mrst_wrap_addr", w_mem_addr, 24'hFFFFFC);
      @(negedge clk) begin rst = 1'b1; start = 1'b0; end

      run(n, en_cnt, bad_cnt);
      chk("r3_done_edge", n, 1148);
      chk("r3_en_cycles", en_cnt, 1024);
      chk("r3_id", id, 24'hFFFFFF);
      do_ack();

      // Bad pairs: pair 5 = {7,7}, pair 9 = {48,1}
      mem[10] = 8'd7;  mem[11] = 8'd7;
      mem[18] = 8'd48; mem[19] = 8'd1;
      run(n, en_cnt, bad_cnt);
      chk("r4_done_edge", n, 1148);
`ifdef MEAS_SEQ_SELCHK_EN
      chk("r4_id", id, 24'hFBBFFF);
      chk("r4_sel_err", sel_err, 1'b1);
`else
      chk("r4_id", id, 24'hFFFFFF);
      chk("r4_sel_err", sel_err, 1'b0);
`endif
      do_ack();
`ifdef MEAS_SEQ_SELCHK_EN
      chk("r4_err_sticky", sel_err, 1'b1);
`endif
      for (int i = 0; i < 64; i++) mem[i] = 8'(i);

      // Next start clears the sticky flag
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      chk("r5_sel_err_clr", sel_err, 1'b0);
      chk("r5_busy", busy, 1'b1);
      chk("r5_id_clr", id, 24'h0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #1;
      chk("end_busy", busy, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
